// File: rtl/request_unit_pkg.sv
// rtl/request_unit_pkg.sv - shared types for the request unit
package request_unit_pkg;

  // Request sequencing: fetch an instruction, optionally wait on data, or stop for good.
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } reqstate_t;

endpackage

// File: rtl/request_unit_sat.sv
// rtl/request_unit_sat.sv - saturating up-counter used for performance counters
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Advance on request but stick at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/request_unit.sv
// rtl/request_unit.sv - instruction/data memory request sequencing with halt and perf counters
module request_unit
  import request_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             cu_dREN,
  input  logic             cu_dWEN,
  input  logic             cu_halt,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             halt,
  output logic             req_err,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
);

  reqstate_t state_q, state_d;
  logic      dren_q, dren_d;
  logic      dwen_q, dwen_d;
  logic      halt_q, halt_d;
  logic      err_q, err_d;
  logic      stall_inc;

  // Next-state and request decode; pc_en is combinational so a hit retires in its own cycle.
  always_comb begin
    state_d   = state_q;
    dren_d    = dren_q;
    dwen_d    = dwen_q;
    err_d     = err_q;
    imemREN   = 1'b0;
    pc_en     = 1'b0;
    stall_inc = 1'b0;
    unique case (state_q)
      FETCH: begin
        imemREN = 1'b1;
        dren_d  = 1'b0;
        dwen_d  = 1'b0;
        if (ihit) begin
          if (cu_halt) begin
            state_d = HALTED;
          end else if (cu_dREN || cu_dWEN) begin
            // A malformed decode with both set is treated as a store.
            state_d = DATA;
            dwen_d  = cu_dWEN;
            dren_d  = cu_dREN & ~cu_dWEN;
            if (cu_dREN && cu_dWEN) begin
              err_d = 1'b1;
            end
          end else begin
            pc_en = 1'b1;
          end
        end else begin
          stall_inc = 1'b1;
        end
      end
      DATA: begin
        // Keep the instruction read alive so imemload stays stable while data is served.
        imemREN = 1'b1;
        if (dhit) begin
          pc_en   = 1'b1;
          state_d = FETCH;
          dren_d  = 1'b0;
          dwen_d  = 1'b0;
        end else begin
          stall_inc = 1'b1;
        end
      end
      HALTED: begin
        dren_d = 1'b0;
        dwen_d = 1'b0;
      end
      default: begin
        state_d = FETCH;
        dren_d  = 1'b0;
        dwen_d  = 1'b0;
      end
    endcase
    halt_d = halt_q | (state_d == HALTED);
  end

  // State and registered request/flag outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      dren_q  <= 1'b0;
      dwen_q  <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dren_q  <= dren_d;
      dwen_q  <= dwen_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

  assign dmemREN = dren_q;
  assign dmemWEN = dwen_q;
  assign halt    = halt_q;
  assign req_err = err_q;

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (pc_en),
    .count (instr_count)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc),
    .count (stall_count)
  );

endmodule

// File: tb/tb_request_unit.sv
// tb/tb_request_unit.sv - directed scoreboard bench for request_unit
module tb_request_unit;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        ihit = 1'b0, dhit = 1'b0, cu_dREN = 1'b0, cu_dWEN = 1'b0, cu_halt = 1'b0;
  logic        imemREN, dmemREN, dmemWEN, pc_en, halt, req_err;
  logic [31:0] instr_count, stall_count;
  logic        s_imemREN, s_dmemREN, s_dmemWEN, s_pc_en, s_halt, s_req_err;
  logic [3:0]  s_instr_count, s_stall_count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [5:0] exp_q[$];
  string      tag_q[$];

  wire [5:0] obs_vec = {imemREN, dmemREN, dmemWEN, pc_en, halt, req_err};

  always #5 clk = ~clk;

  request_unit #(.CNT_W(32)) dut (
    .CLK(clk), .nRST(nrst), .ihit(ihit), .dhit(dhit),
    .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
    .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .pc_en(pc_en), .halt(halt), .req_err(req_err),
    .instr_count(instr_count), .stall_count(stall_count)
  );

  request_unit #(.CNT_W(4)) dut4 (
    .CLK(clk), .nRST(nrst), .ihit(ihit), .dhit(dhit),
    .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
    .imemREN(s_imemREN), .dmemREN(s_dmemREN), .dmemWEN(s_dmemWEN),
    .pc_en(s_pc_en), .halt(s_halt), .req_err(s_req_err),
    .instr_count(s_instr_count), .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // in = {ihit, dhit, cu_dREN, cu_dWEN, cu_halt}
  // exp = {imemREN, dmemREN, dmemWEN, pc_en, halt, req_err}
  task automatic step(input string tag, input logic [4:0] in, input logic [5:0] exp);
    {ihit, dhit, cu_dREN, cu_dWEN, cu_halt} = in;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    chk(tag_q.pop_front(), {26'b0, obs_vec}, {26'b0, exp_q.pop_front()});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    nrst = 1'b0;
    {ihit, dhit, cu_dREN, cu_dWEN, cu_halt} = 5'b0;
    #2;
    chk({tag, "_outs"}, {26'b0, obs_vec}, 32'h20);
    chk({tag, "_instr"}, instr_count, 32'd0);
    chk({tag, "_stall"}, stall_count, 32'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  initial begin
    do_reset("reset0");

    for (int i = 0; i < 3; i++) step("idle_fetch", 5'b00000, 6'b100000);
    chk("idle_stall3", stall_count, 32'd3);
    chk("idle_instr0", instr_count, 32'd0);

    do_reset("reset1");
    for (int i = 0; i < 4; i++) step("alu_retire", 5'b10000, 6'b100100);
    chk("alu_instr4", instr_count, 32'd4);
    chk("alu_stall0", stall_count, 32'd0);

    step("load_ihit",     5'b10100, 6'b100000);
    step("load_wait1",    5'b00000, 6'b110000);
    step("load_spurious", 5'b10000, 6'b110000);
    step("load_dhit",     5'b01000, 6'b110100);
    chk("load_instr", instr_count, 32'd5);
    chk("load_stall", stall_count, 32'd2);
    step("post_load_fetch", 5'b10000, 6'b100100);

    step("both_ihit",  5'b10110, 6'b100000);
    step("both_dhit",  5'b01000, 6'b101101);
    step("both_after", 5'b10000, 6'b100101);

    step("halt_ihit",  5'b10001, 6'b100001);
    step("halt_entry", 5'b00000, 6'b000011);
    for (int i = 0; i < 10; i++)
      step("halt_pulse", (i % 2 == 1) ? 5'b01100 : 5'b10010, 6'b000011);
    chk("halt_instr_frozen", instr_count, 32'd8);
    chk("halt_stall_frozen", stall_count, 32'd2);

    do_reset("reset2");
    for (int i = 0; i < 20; i++) step("sat_stall", 5'b00000, 6'b100000);
    chk("sat_stall_w4", {28'b0, s_stall_count}, 32'd15);
    chk("sat_stall_w32", stall_count, 32'd20);

    step("mid_load_ihit", 5'b10100, 6'b100000);
    step("mid_load_wait", 5'b00000, 6'b110000);
    {ihit, dhit, cu_dREN, cu_dWEN, cu_halt} = 5'b0;
    #2;
    nrst = 1'b0;
    #1;
    chk("async_outs", {26'b0, obs_vec}, 32'h20);
    chk("async_instr", instr_count, 32'd0);
    chk("async_stall", stall_count, 32'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    step("post_reset_fetch", 5'b10000, 6'b100100);
    chk("post_reset_instr", instr_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
